iserdes_deser: RTL and testbench

- Single-clock deserializer that sits directly downstream of the I/O clock buffer.
- Samples a serial input bit on every CLK edge into a shift register.
- Captures a parallel word whenever the buffer's SERDES strobe (IOCE) is asserted.
- Supports bit-slip word alignment, so the link-training logic can find word boundaries without touching the clock buffer.

---
 rtl/iserdes_deser.sv | 101 ++++++++++
 tb/tb_iserdes_deser.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iserdes_deser.sv
// Single-clock deserializer: shifts D every CLK, captures a word on IOCE, supports bit-slip.
// Optional strobe-spacing checker enabled by defining ISERDES_DESER_IOCE_CHECK_EN.
module iserdes_deser #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter string       MSB_FIRST  = "TRUE"
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  D,
  input  logic                  IOCE,
  input  logic                  BITSLIP,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  VALID,
  output logic [2:0]            SLIP_COUNT,
  output logic                  ERR
);

  localparam logic [2:0] SlipMax = 3'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_shift, sr_d;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  valid_q;
  logic                  bitslip_q;
  logic [2:0]            slip_cnt_q;
  logic                  slip;

  generate
    if (MSB_FIRST == "TRUE") begin : g_msb_first
      assign sr_shift = {sr_q[DATA_WIDTH-2:0], D};
    end else begin : g_lsb_first
      assign sr_shift = {D, sr_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  assign slip = BITSLIP & ~bitslip_q;

  // A slip swallows this cycle's sample, moving the word boundary by one bit.
  always_comb begin
    sr_d = sr_shift;
    if (slip) begin
      sr_d = sr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_q       <= '0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      bitslip_q  <= 1'b0;
      slip_cnt_q <= 3'd0;
    end else begin
      sr_q      <= sr_d;
      bitslip_q <= BITSLIP;
      valid_q   <= IOCE;
      if (IOCE) begin
        q_q <= sr_d;
      end
      if (slip) begin
        slip_cnt_q <= (slip_cnt_q == SlipMax) ? 3'd0 : slip_cnt_q + 3'd1;
      end
    end
  end

  assign Q          = q_q;
  assign VALID      = valid_q;
  assign SLIP_COUNT = slip_cnt_q;

`ifdef ISERDES_DESER_IOCE_CHECK_EN
  logic [3:0] space_cnt_q;
  logic       seen_q;
  logic       err_q;

  // Counter reads k on the k-th edge after a strobe; saturation at 15 means the strobe was lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      space_cnt_q <= 4'd0;
      seen_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (IOCE) begin
        space_cnt_q <= 4'd1;
        seen_q      <= 1'b1;
        if (seen_q && (space_cnt_q != 4'(DATA_WIDTH))) begin
          err_q <= 1'b1;
        end
      end else if (space_cnt_q != 4'd15) begin
        space_cnt_q <= space_cnt_q + 4'd1;
      end
      if (seen_q && (space_cnt_q == 4'd15)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_iserdes_deser.sv
// Self-checking bench for iserdes_deser: MSB-first and LSB-first instances share one stimulus,
// checked against a bit-history reference model.
module tb_iserdes_deser;

  localparam int W = 4;
`ifdef ISERDES_DESER_IOCE_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         drv_rst = 1'b1, drv_d = 1'b0, drv_ioce = 1'b0, drv_bs = 1'b0;
  logic [W-1:0] q_m, q_l;
  logic         valid_m, valid_l, err_m, err_l;
  logic [2:0]   slip_m, slip_l;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit           hist[$];
  logic [W-1:0] eq_m, eq_l;
  logic         ev, ee;
  logic [2:0]   es;
  bit           prev_bs, seen;
  int           edge_n, last_ioce;

  always #5 clk = ~clk;

  iserdes_deser #(.DATA_WIDTH(W), .MSB_FIRST("TRUE")) u_msb (
    .CLK(clk), .RST(drv_rst), .D(drv_d), .IOCE(drv_ioce), .BITSLIP(drv_bs),
    .Q(q_m), .VALID(valid_m), .SLIP_COUNT(slip_m), .ERR(err_m)
  );

  iserdes_deser #(.DATA_WIDTH(W), .MSB_FIRST("FALSE")) u_lsb (
    .CLK(clk), .RST(drv_rst), .D(drv_d), .IOCE(drv_ioce), .BITSLIP(drv_bs),
    .Q(q_l), .VALID(valid_l), .SLIP_COUNT(slip_l), .ERR(err_l)
  );

  // Model: a word is the last W accepted bits, oldest first; slipped samples are never accepted.
  task automatic model_edge(input logic d, input logic ioce, input logic bs, input logic rst);
    bit slip;
    int n, idx, gap;
    bit b;
    if (rst) begin
      hist.delete();
      eq_m = '0; eq_l = '0; ev = 1'b0; es = 3'd0; ee = 1'b0;
      prev_bs = 1'b0; seen = 1'b0; edge_n = 0; last_ioce = 0;
      return;
    end
    edge_n++;
    slip    = bs && !prev_bs;
    prev_bs = bs;
    if (!slip) hist.push_back(d);
    if (hist.size() > 8) void'(hist.pop_front());
    if (slip) es = 3'((int'(es) + 1) % W);
    gap = edge_n - last_ioce;
    if (ChkEn && seen && (ioce ? (gap != W) : (gap >= 15))) ee = 1'b1;
    if (ioce) begin
      seen = 1'b1;
      last_ioce = edge_n;
      n = hist.size();
      for (int k = 0; k < W; k++) begin
        idx = n - W + k;
        b = (idx >= 0) ? hist[idx] : 1'b0;
        eq_m[W-1-k] = b;
        eq_l[k]     = b;
      end
    end
    ev = ioce;
  endtask

  task automatic tick(input logic d, input logic ioce, input logic bs, input logic rst);
    @(negedge clk);
    drv_d = d; drv_ioce = ioce; drv_bs = bs; drv_rst = rst;
    @(posedge clk);
    model_edge(d, ioce, bs, rst);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if ({q_m, q_l, valid_m, valid_l, slip_m, slip_l, err_m, err_l} !== 18'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0",
               {q_m, q_l, valid_m, valid_l, slip_m, slip_l, err_m, err_l});
    end
  endtask

  task automatic test_msb_first();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (q_m !== 4'b1011 || valid_m !== 1'b1) begin
      bad++;
      $display("FAIL msb_word: got q=%b v=%b want q=1011 v=1", q_m, valid_m);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (valid_m !== 1'b0 || q_m !== 4'b1011) begin
      bad++;
      $display("FAIL msb_valid_pulse: got q=%b v=%b want q=1011 v=0", q_m, valid_m);
    end
  endtask

  task automatic test_lsb_first();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (q_l !== 4'b0001 || valid_l !== 1'b1) begin
      bad++;
      $display("FAIL lsb_word: got q=%b v=%b want q=0001 v=1", q_l, valid_l);
    end
  endtask

  task automatic test_bitslip();
    logic [3:0] s;
    logic       bs;
    s = 4'b1011;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 44; c++) begin
      // One pulse held three cycles, then three single-cycle pulses: four slips in total.
      bs = (c >= 12 && c <= 14) || c == 24 || c == 28 || c == 32;
      tick(s[3 - (c % 4)], (c % 4) == 3, bs, 1'b0);
      total++;
      if ({q_m, q_l, valid_m, slip_m} !== {eq_m, eq_l, ev, es}) begin
        bad++;
        $display("FAIL bitslip_cycle%0d: got q=%b/%b v=%b sc=%0d want q=%b/%b v=%b sc=%0d",
                 c, q_m, q_l, valid_m, slip_m, eq_m, eq_l, ev, es);
      end
      if (c == 11 || c == 43) begin
        total++;
        if (q_m !== 4'b1011) begin
          bad++;
          $display("FAIL bitslip_word%0d: got %b want 1011", c, q_m);
        end
      end
      if (c == 14 || c == 23) begin
        total++;
        if (slip_m !== 3'd1) begin
          bad++;
          $display("FAIL slip_held%0d: got %0d want 1", c, slip_m);
        end
      end
    end
    total++;
    if (slip_m !== 3'd0 || slip_l !== 3'd0) begin
      bad++;
      $display("FAIL slip_wrap: got %0d/%0d want 0", slip_m, slip_l);
    end
  endtask

  task automatic test_slip_with_ioce();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (q_m !== 4'b1011 || q_l !== eq_l || valid_m !== 1'b1 || slip_m !== 3'd1) begin
      bad++;
      $display("FAIL slip_ioce: got q=%b/%b v=%b sc=%0d want q=1011/%b v=1 sc=1",
               q_m, q_l, valid_m, slip_m, eq_l);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_word();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if ({q_m, q_l, valid_m, slip_m, err_m} !== {4'b0011, 4'b1100, 1'b1, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_word: got q=%b/%b v=%b sc=%0d e=%b want q=0011/1100 v=1 sc=0 e=0",
               q_m, q_l, valid_m, slip_m, err_m);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      total++;
      if ({q_m, q_l, valid_m, valid_l} !== {eq_m, eq_l, 2'b11}) begin
        bad++;
        $display("FAIL back_to_back%0d: got q=%b/%b v=%b want q=%b/%b v=1",
                 c, q_m, q_l, valid_m, eq_m, eq_l);
      end
    end
  endtask

  task automatic run_gap(input int gap);
    for (int i = 1; i < gap; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ioce_check();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    run_gap(2);
    run_gap(4);
    run_gap(4);
    total++;
    if (err_m !== 1'b0) begin
      bad++;
      $display("FAIL err_regular: got %b want 0", err_m);
    end
    run_gap(3);
    total++;
    if (err_m !== ChkEn || err_l !== ee) begin
      bad++;
      $display("FAIL err_short_gap: got %b/%b want %b", err_m, err_l, ChkEn);
    end
    run_gap(4);
    run_gap(4);
    total++;
    if (err_m !== ChkEn) begin
      bad++;
      $display("FAIL err_sticky: got %b want %b", err_m, ChkEn);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (err_m !== 1'b0) begin
      bad++;
      $display("FAIL err_reset_clear: got %b want 0", err_m);
    end
    run_gap(1);
    for (int i = 0; i < 14; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (err_m !== 1'b0) begin
      bad++;
      $display("FAIL err_before_sat: got %b want 0", err_m);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (err_m !== ChkEn || err_m !== ee) begin
      bad++;
      $display("FAIL err_lost_strobe: got %b want %b", err_m, ChkEn);
    end
  endtask

  task automatic test_random();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      tick(1'($urandom_range(0, 1)),
           ((c % 4) == 3) ^ ($urandom_range(0, 15) == 0),
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 199) == 0);
      total++;
      if ({q_m, q_l, valid_m, valid_l, slip_m, slip_l, err_m, err_l} !==
          {eq_m, eq_l, ev, ev, es, es, ee, ee}) begin
        bad++;
        $display("FAIL random%0d: got q=%b/%b v=%b%b sc=%0d/%0d e=%b%b want q=%b/%b v=%b sc=%0d e=%b",
                 c, q_m, q_l, valid_m, valid_l, slip_m, slip_l, err_m, err_l, eq_m, eq_l, ev, es, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_bitslip();
    test_slip_with_ioce();
    test_reset_mid_word();
    test_back_to_back();
    test_ioce_check();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
